// File: rtl/data_mem_seq.sv
// ---------------------------------------------------------------------------
// data_mem_seq
//
// Byte-addressable data memory built from DATA_W-bit words with per-byte
// write enables. Little-endian: byte k of a word lives at byte address A+k.
// Word accesses that straddle a word boundary are split into two beats:
// the word holding req_addr first, then the following word (wrapping at the
// top of the address space). After reset the block zeroes the whole array,
// one word per cycle, before it accepts requests.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-low reset
//   req_valid  request present
//   req_ready  request accepted this cycle when req_valid is also high
//   req_we     1 = write, 0 = read
//   req_sb     1 = single-byte access, 0 = full-word access
//   req_sext   byte reads only: 1 = sign-extend, 0 = zero-extend
//   req_addr   byte address
//   req_wdata  write data; byte writes use bits [7:0]
//   rsp_valid  one-cycle pulse, rsp_rdata carries read data
//   rsp_rdata  read data; holds its last value while rsp_valid is low
//   busy       high while clearing the array or finishing a split access
// ---------------------------------------------------------------------------
module data_mem_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_sb,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam int NB     = DATA_W / 8;        // bytes per word
    localparam int OFF_W  = $clog2(NB);        // byte-offset bits in an address
    localparam int WIDX_W = ADDR_W - OFF_W;    // word-index bits
    localparam int NW     = 2 ** WIDX_W;       // words in the array

    localparam logic [NB-1:0] ALL_LANES = '1;
    localparam logic [NB-1:0] LANE0     = NB'(1);

    if (DATA_W != 16 && DATA_W != 32) begin : g_bad_data_w
        $error("data_mem_seq: DATA_W must be 16 or 32");
    end

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SPLIT
    } state_t;

    state_t state;
    state_t next_state;

    // Storage
    logic [DATA_W-1:0] mem [NW];

    // Request decode
    logic [OFF_W-1:0]  req_off;
    logic [WIDX_W-1:0] req_widx;

    // Single read port and single write port into the array
    logic [WIDX_W-1:0] rd_widx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] byte_ext;
    logic [NB-1:0]     mem_we;
    logic [WIDX_W-1:0] mem_widx;
    logic [DATA_W-1:0] mem_wdata;

    // Clear counter for the INIT sweep
    logic [WIDX_W-1:0] init_cnt;
    logic [WIDX_W-1:0] init_cnt_nxt;

    // Context carried from the first beat of a split access into SPLIT
    logic              split_load;
    logic [WIDX_W-1:0] split_widx;
    logic [OFF_W-1:0]  split_off;
    logic [OFF_W:0]    split_rem;
    logic              split_we;
    logic [DATA_W-1:0] split_wdata;
    logic [DATA_W-1:0] hold_rdata;

    logic              rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_rdata_nxt;

    assign req_off  = req_addr[OFF_W-1:0];
    assign req_widx = req_addr[ADDR_W-1:OFF_W];

    // Combinational read of the selected word. Shifting it down by the
    // byte offset gives both the addressed byte (lane 0) and the low part
    // of a split word read (the bytes from req_addr to the end of the word).
    assign rd_word  = mem[rd_widx];
    assign rd_shift = rd_word >> {req_off, 3'b000};
    assign byte_ext = req_sext ? {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]}
                               : {{(DATA_W-8){1'b0}},        rd_shift[7:0]};

    // Bytes still to be handled in the second beat sit at the top of the
    // request word; this many bytes were already handled in the first beat.
    assign split_rem = (OFF_W+1)'(NB) - {1'b0, split_off};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state, handshake outputs and memory port control
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        next_state    = state;
        init_cnt_nxt  = init_cnt;
        req_ready     = 1'b0;
        busy          = 1'b1;
        rd_widx       = req_widx;
        mem_we        = '0;
        mem_widx      = req_widx;
        mem_wdata     = req_wdata << {req_off, 3'b000};
        split_load    = 1'b0;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;

        unique case (state)
            ST_INIT: begin
                mem_widx     = init_cnt;
                mem_wdata    = '0;
                mem_we       = ALL_LANES;
                init_cnt_nxt = init_cnt + 1'b1;
                if (&init_cnt) begin
                    next_state = ST_IDLE;
                end
            end

            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (req_sb) begin
                        // Byte access: replicate the byte on every lane and
                        // let the lane enable pick the addressed one.
                        mem_wdata     = {NB{req_wdata[7:0]}};
                        mem_we        = {NB{req_we}} & (LANE0 << req_off);
                        rsp_valid_nxt = ~req_we;
                        if (!req_we) begin
                            rsp_rdata_nxt = byte_ext;
                        end
                    end else begin
                        // First (or only) beat of a word access: lanes from
                        // the offset upward take the low request bytes.
                        mem_we = {NB{req_we}} & (ALL_LANES << req_off);
                        if (req_off == '0) begin
                            rsp_valid_nxt = ~req_we;
                            if (!req_we) begin
                                rsp_rdata_nxt = rd_word;
                            end
                        end else begin
                            split_load = 1'b1;
                            next_state = ST_SPLIT;
                        end
                    end
                end
            end

            ST_SPLIT: begin
                // Second beat: lanes below the offset of the next word take
                // the high request bytes.
                rd_widx   = split_widx;
                mem_widx  = split_widx;
                mem_wdata = split_wdata >> {split_rem, 3'b000};
                mem_we    = {NB{split_we}} & ~(ALL_LANES << split_off);
                rsp_valid_nxt = ~split_we;
                if (!split_we) begin
                    rsp_rdata_nxt = hold_rdata | (rd_word << {split_rem, 3'b000});
                end
                next_state = ST_IDLE;
            end

            default: begin
                next_state = ST_INIT;
            end
        endcase

        // A reset edge abandons whatever is in flight, including the second
        // beat of a split write.
        if (!reset) begin
            mem_we = '0;
        end
    end

    // ------------------------------------------------------------------
    // Init counter and response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            init_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            init_cnt  <= init_cnt_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Split-access context. Only read while in SPLIT, which is entered only
    // on the cycle these are loaded, so they need no reset value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (split_load) begin
            split_widx  <= req_widx + 1'b1;   // wraps to word 0 past the top
            split_off   <= req_off;
            split_we    <= req_we;
            split_wdata <= req_wdata;
            hold_rdata  <= rd_shift;
        end
    end

    // ------------------------------------------------------------------
    // Storage array with per-byte write enables
    // ------------------------------------------------------------------
    // NOTE: the array has no reset branch so it can map onto RAM; the INIT
    // sweep is what gives it defined contents after reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_we[b]) begin
                mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_seq.sv
// ---------------------------------------------------------------------------
// tb_data_mem_seq
//
// Directed bench for data_mem_seq at its default size (256 bytes, 16-bit
// words). A byte-array reference model supplies every expected read value;
// reads push their expectation and due cycle onto a scoreboard queue, and a
// monitor pops and compares each rsp_valid pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_mem_seq;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk       = 1'b0;
    logic              reset     = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we    = 1'b0;
    logic              req_sb    = 1'b0;
    logic              req_sext  = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    data_mem_seq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_sb    (req_sb),
        .req_sext  (req_sext),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks    = 0;
    int passes    = 0;
    int fails     = 0;
    int rsp_count = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  addr;
        int          due;
    } exp_t;

    exp_t        sb_q [$];
    exp_t        mon_e;
    logic [15:0] last_exp = '0;
    logic [7:0]  ref_mem [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_read(input logic [7:0] a, input logic sb, input logic sext);
        logic [7:0] a1;
        logic [7:0] b0;
        logic [7:0] b1;
        a1 = a + 8'd1;
        b0 = ref_mem[a];
        b1 = ref_mem[a1];
        if (sb) return sext ? {{8{b0[7]}}, b0} : {8'h00, b0};
        return {b1, b0};
    endfunction

    task automatic model_write(input logic [7:0] a, input logic sb, input logic [15:0] d);
        logic [7:0] a1;
        a1 = a + 8'd1;
        ref_mem[a] = d[7:0];
        if (!sb) ref_mem[a1] = d[15:8];
    endtask

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_count++;
            check("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check($sformatf("rsp_data@%02h", mon_e.addr), 32'(rsp_rdata), 32'(mon_e.data));
                check($sformatf("rsp_cycle@%02h", mon_e.addr), cyc, mon_e.due);
                last_exp = mon_e.data;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_req(input logic we, input logic sb, input logic sext,
                          input logic [7:0] addr, input logic [15:0] wdata,
                          input bit expect_rsp);
        int   n = 0;
        exp_t e;
        while (req_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_sb    = sb;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
        e.data    = model_read(addr, sb, sext);
        e.addr    = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (we) begin
            model_write(addr, sb, wdata);
        end else if (expect_rsp) begin
            // Aligned and byte reads respond right after the accept edge,
            // split reads one edge later.
            e.due = cyc + ((!sb && addr[0]) ? 1 : 0);
            sb_q.push_back(e);
        end
    endtask

    task automatic rd(input logic sb, input logic sext, input logic [7:0] addr);
        do_req(1'b0, sb, sext, addr, 16'h0000, 1'b1);
    endtask

    task automatic wr(input logic sb, input logic [7:0] addr, input logic [15:0] d);
        do_req(1'b1, sb, 1'b0, addr, d, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("rst_busy",      32'(busy),      32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        reset = 1'b1;
    endtask

    task automatic init_wait();
        int n       = 0;
        bit busy_ok = 1'b1;
        while (req_ready !== 1'b1 && n < 400) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("init_cycles", n, 128);
        check("init_busy",   32'(busy_ok), 32'd1);
        check("idle_busy",   32'(busy),    32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int rc0;

        // Reset, INIT sweep length, cleared contents
        apply_reset();
        init_wait();
        rd(1'b0, 1'b0, 8'h7E);
        drain();

        // Aligned word write/read, byte read zero-extended
        wr(1'b0, 8'h00, 16'h2BCD);
        rd(1'b0, 1'b0, 8'h00);
        rd(1'b1, 1'b0, 8'h01);
        drain();

        // Sign and zero extension of byte reads
        wr(1'b0, 8'h10, 16'h80FF);
        rd(1'b1, 1'b1, 8'h10);
        rd(1'b1, 1'b1, 8'h11);
        rd(1'b1, 1'b0, 8'h11);
        drain();

        // Misaligned word write: one SPLIT cycle with req_ready low
        wr(1'b0, 8'h05, 16'hBEEF);
        check("split_ready_low", 32'(req_ready), 32'd0);
        check("split_busy",      32'(busy),      32'd1);
        @(posedge clk); #1;
        check("split_ready_back", 32'(req_ready), 32'd1);
        rd(1'b0, 1'b0, 8'h04);
        rd(1'b0, 1'b0, 8'h06);
        rd(1'b0, 1'b0, 8'h05);
        drain();

        // Wrap at the top of the address space
        wr(1'b0, 8'hFF, 16'h1234);
        rd(1'b1, 1'b0, 8'hFF);
        rd(1'b1, 1'b0, 8'h00);
        rd(1'b1, 1'b0, 8'hFE);
        rd(1'b0, 1'b0, 8'h00);
        rd(1'b0, 1'b0, 8'hFF);
        drain();

        // Byte writes leave neighbouring bytes alone; sext ignored on words
        wr(1'b1, 8'h21, 16'hA5C3);
        rd(1'b0, 1'b1, 8'h20);
        rd(1'b0, 1'b1, 8'h21);
        drain();

        // rsp_rdata holds its value once the pulse is over
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rsp_hold_valid", 32'(rsp_valid), 32'd0);
        check("rsp_hold_data",  32'(rsp_rdata), 32'(last_exp));

        // Random mix checked against the byte model
        for (int i = 0; i < 60; i++) begin
            logic [7:0]  a;
            logic [15:0] d;
            a = 8'($urandom_range(0, 255));
            d = 16'($urandom_range(0, 65535));
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), a, d, 1'b1);
        end
        drain();

        // Reset during the SPLIT beat of a read: no response, INIT reruns
        rc0 = rsp_count;
        do_req(1'b0, 1'b0, 1'b0, 8'h05, 16'h0000, 1'b0);
        apply_reset();
        init_wait();
        check("abort_no_rsp", rsp_count, rc0);
        rd(1'b0, 1'b0, 8'h05);
        rd(1'b0, 1'b0, 8'h00);
        rd(1'b1, 1'b1, 8'h10);
        rd(1'b0, 1'b0, 8'hFF);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
